audio_dac_tx: RTL and testbench

//  Sink end of the synth audio path. Accepts the 32-bit signed mixed TONE word, scales and saturates it to
//  DAC width, and buffers it in a small FIFO. Serialises it as I2S (mono, same sample on L and R) to the
//  WM8731 codec: AUD_BCLK, AUD_DACLRCK, AUD_DACDAT. Pulses SAMPLE_REQ once per frame to pace the voice-summing FSM.

---
 rtl/audio_dac_tx_if.sv | 11 +
 rtl/audio_dac_tx.sv | 155 +++++++++++++++
 tb/tb_audio_dac_tx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/audio_dac_tx_if.sv
// rtl/audio_dac_tx_if.sv - mixed tone sample stream from the synth datapath into the DAC transmitter
interface audio_dac_tx_if #(
  parameter int TONE_W = 32
);
  logic [TONE_W-1:0] TONE_IN;
  logic              TONE_VALID;
  logic              TONE_READY;

  modport master (output TONE_IN, output TONE_VALID, input  TONE_READY);
  modport slave  (input  TONE_IN, input  TONE_VALID, output TONE_READY);
endinterface

// File: rtl/audio_dac_tx.sv
// rtl/audio_dac_tx.sv - scales/saturates tone samples, buffers them and serialises mono I2S to the codec
module audio_dac_tx #(
  parameter int DAC_W      = 16,
  parameter int GAIN_SHIFT = 8,
  parameter int BCLK_DIV   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          EN,
  audio_dac_tx_if.slave                 tone,
  output logic                          SAMPLE_REQ,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          UNDERRUN,
  input  logic                          CLR_UNDERRUN,
  output logic                          AUD_BCLK,
  output logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int IW    = (DAC_W > 1) ? $clog2(DAC_W) : 1;

  localparam logic signed [31:0] SAT_MAX  = (32'sd1 <<< (DAC_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN  = -(32'sd1 <<< (DAC_W - 1));
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [AW:0]        FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  logic signed [31:0] shifted;
  logic [DAC_W-1:0]   sat_sample;

  logic [DAC_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic [AW:0]        count_next;
  logic [DAC_W-1:0]   hold;

  logic [DIV_W-1:0]   div;
  logic [5:0]         bit_cnt;
  logic [5:0]         bit_cnt_next;
  logic [4:0]         slot_k;
  logic [IW-1:0]      slot_idx;
  logic               slot_bit;

  logic               push;
  logic               fall_event;
  logic               frame_start;
  logic               pop;

  assign shifted = $signed(tone.TONE_IN) >>> GAIN_SHIFT;

  always_comb begin
    sat_sample = shifted[DAC_W-1:0];
    if (shifted > SAT_MAX) begin
      sat_sample = {1'b0, {(DAC_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_sample = {1'b1, {(DAC_W-1){1'b0}}};
    end
  end

  assign push        = tone.TONE_VALID & tone.TONE_READY;
  assign fall_event  = EN && (div == DIV_LAST) && AUD_BCLK;
  assign frame_start = fall_event && (bit_cnt == 6'd63);
  assign pop         = frame_start && (count != '0);
  assign FIFO_LEVEL  = count;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array carries no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= sat_sample;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      tone.TONE_READY <= 1'b0;
      hold            <= '0;
      UNDERRUN        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      count           <= count_next;
      tone.TONE_READY <= (count_next != FULL_LVL);
      // A new underrun wins over a clear arriving in the same cycle.
      if (frame_start && (count == '0)) begin
        UNDERRUN <= 1'b1;
      end else if (CLR_UNDERRUN) begin
        UNDERRUN <= 1'b0;
      end
    end
  end

  assign bit_cnt_next = bit_cnt + 6'd1;
  assign slot_k       = bit_cnt_next[4:0];
  assign slot_idx     = IW'(DAC_W - int'(slot_k));

  // I2S one-bit delay: slot position 1 carries the MSB.
  always_comb begin
    slot_bit = 1'b0;
    if ((slot_k != 5'd0) && (int'(slot_k) <= DAC_W)) begin
      slot_bit = hold[slot_idx];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div         <= '0;
      bit_cnt     <= 6'd63;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
      SAMPLE_REQ  <= 1'b0;
    end else if (!EN) begin
      div         <= '0;
      bit_cnt     <= 6'd63;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
      SAMPLE_REQ  <= 1'b0;
    end else begin
      SAMPLE_REQ <= frame_start;
      if (div == DIV_LAST) begin
        div      <= '0;
        AUD_BCLK <= ~AUD_BCLK;
        if (AUD_BCLK) begin
          bit_cnt     <= bit_cnt_next;
          AUD_DACLRCK <= bit_cnt_next[5];
          AUD_DACDAT  <= slot_bit;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb/tb_audio_dac_tx.sv - directed self-checking bench for audio_dac_tx
module tb_audio_dac_tx;

  logic       CLK;
  logic       RESET_N;
  logic       EN;
  logic       SAMPLE_REQ;
  logic [2:0] FIFO_LEVEL;
  logic       UNDERRUN;
  logic       CLR_UNDERRUN;
  logic       AUD_BCLK;
  logic       AUD_DACLRCK;
  logic       AUD_DACDAT;

  int checks   = 0;
  int failures = 0;
  int n_wait;

  audio_dac_tx_if tone_if ();

  audio_dac_tx dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .EN           (EN),
    .tone         (tone_if.slave),
    .SAMPLE_REQ   (SAMPLE_REQ),
    .FIFO_LEVEL   (FIFO_LEVEL),
    .UNDERRUN     (UNDERRUN),
    .CLR_UNDERRUN (CLR_UNDERRUN),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    tone_if.TONE_IN    = d;
    tone_if.TONE_VALID = 1'b1;
    @(negedge CLK);
    tone_if.TONE_VALID = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge CLK);
      if (SAMPLE_REQ) begin
        n = i;
        break;
      end
    end
  endtask

  // Called on the cycle SAMPLE_REQ is seen; samples DACDAT/LRCK at every BCLK rise of one frame.
  task automatic capture_frame(input logic [15:0] exp, input string tag);
    logic [63:0] bits;
    logic [63:0] lr;
    logic        prev;
    int          rises;
    int          reqs;
    bits  = '0;
    lr    = '0;
    rises = 0;
    reqs  = 0;
    prev  = AUD_BCLK;
    for (int i = 1; i <= 1024; i++) begin
      @(negedge CLK);
      if (i < 1024 && SAMPLE_REQ) reqs++;
      if (AUD_BCLK && !prev) begin
        bits = {bits[62:0], AUD_DACDAT};
        lr   = {lr[62:0], AUD_DACLRCK};
        rises++;
      end
      prev = AUD_BCLK;
    end
    chk({tag, "_data"}, bits, {1'b0, exp, 15'b0, 1'b0, exp, 15'b0});
    chk({tag, "_lrck"}, lr, 64'h00000000_FFFFFFFF);
    chk({tag, "_rises"}, 64'(rises), 64'd64);
    chk({tag, "_req_mid"}, 64'(reqs), 64'd0);
    chk({tag, "_req_period"}, 64'(SAMPLE_REQ), 64'd1);
  endtask

  initial begin
    RESET_N            = 1'b1;
    EN                 = 1'b0;
    CLR_UNDERRUN       = 1'b0;
    tone_if.TONE_IN    = '0;
    tone_if.TONE_VALID = 1'b0;

    // Reset state
    #3 RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", 64'(tone_if.TONE_READY), 64'd0);
    chk("rst_level", 64'(FIFO_LEVEL), 64'd0);
    chk("rst_serial", 64'({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, SAMPLE_REQ, UNDERRUN}), 64'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("rel_ready", 64'(tone_if.TONE_READY), 64'd1);
    chk("rel_level", 64'(FIFO_LEVEL), 64'd0);

    // Serial frame of 0xFFA5C300, then an underrun frame repeating it
    push(32'hFFA5C300);
    chk("push_level", 64'(FIFO_LEVEL), 64'd1);
    EN = 1'b1;
    wait_req(n_wait);
    chk("en_to_req_a", 64'(n_wait), 64'd16);
    chk("pop_level_a", 64'(FIFO_LEVEL), 64'd0);
    chk("no_underrun", 64'(UNDERRUN), 64'd0);
    capture_frame(16'hA5C3, "frame_a5c3");
    chk("underrun_set", 64'(UNDERRUN), 64'd1);
    capture_frame(16'hA5C3, "frame_repeat");

    // Clear alone, then clear colliding with a new underrun frame start
    CLR_UNDERRUN = 1'b1;
    @(negedge CLK);
    CLR_UNDERRUN = 1'b0;
    chk("clr_underrun", 64'(UNDERRUN), 64'd0);
    repeat (1022) @(negedge CLK);
    CLR_UNDERRUN = 1'b1;
    @(negedge CLK);
    CLR_UNDERRUN = 1'b0;
    chk("clr_vs_set_req", 64'(SAMPLE_REQ), 64'd1);
    chk("clr_vs_set", 64'(UNDERRUN), 64'd1);

    // EN dropped in right slot, bit 1 (b=33, MSB of 0xA5C3 = 1)
    push(32'h7FFFFFFF);
    chk("push_sat_pos", 64'(FIFO_LEVEL), 64'd1);
    repeat (536) @(negedge CLK);
    chk("mid_frame_serial", 64'({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT}), 64'b111);
    EN = 1'b0;
    @(negedge CLK);
    chk("en_drop_serial", 64'({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT}), 64'd0);
    chk("en_drop_level", 64'(FIFO_LEVEL), 64'd1);

    // Fill to full while disabled; fifth push is refused
    push(32'h80000000);
    push(32'h00012300);
    push(32'hFFFFFF00);
    chk("full_level", 64'(FIFO_LEVEL), 64'd4);
    chk("full_ready", 64'(tone_if.TONE_READY), 64'd0);
    push(32'h00005500);
    chk("full_reject", 64'(FIFO_LEVEL), 64'd4);

    // Re-enable: pop 16 cycles later, then saturation results in order
    EN = 1'b1;
    wait_req(n_wait);
    chk("en_to_req_b", 64'(n_wait), 64'd16);
    chk("pop_level_b", 64'(FIFO_LEVEL), 64'd3);
    chk("pop_ready_b", 64'(tone_if.TONE_READY), 64'd1);
    capture_frame(16'h7FFF, "sat_pos");
    capture_frame(16'h8000, "sat_neg");
    capture_frame(16'h0123, "pass_pos");
    capture_frame(16'hFFFF, "pass_neg");
    chk("end_level", 64'(FIFO_LEVEL), 64'd0);
    chk("end_underrun", 64'(UNDERRUN), 64'd1);

    // Asynchronous reset mid-frame
    push(32'h00012300);
    repeat (536) @(negedge CLK);
    chk("pre_rst_bclk", 64'(AUD_BCLK), 64'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_rst_serial", 64'({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, SAMPLE_REQ, UNDERRUN}), 64'd0);
    chk("async_rst_ready", 64'(tone_if.TONE_READY), 64'd0);
    chk("async_rst_level", 64'(FIFO_LEVEL), 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("rel2_ready", 64'(tone_if.TONE_READY), 64'd1);
    chk("rel2_level", 64'(FIFO_LEVEL), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
